fdma_frame_writer: RTL and testbench
====================================

# fdma_frame_writer

Upstream write-side feeder for the `app_fdma` SDRAM burst engine. It accepts a 32-bit video word stream, buffers it in an internal single-clock FIFO, and slices each frame into `fdma_wareq` write transactions of at most `BURST_WORDS` words. It generates frame-buffer byte addresses and supplies `fdma_wdata` in step with `fdma_wvalid`.

## Interface
- `BURST_WORDS`, 256: max words per `fdma_wareq` transaction; range 1..256.
- `FIFO_DEPTH`, 512: FIFO words; power of two, at least 2*`BURST_WORDS`.
- `FRAME_WORDS`, 307200: 32-bit words per frame; range 1..2^21-1.
- `BASE_ADDR`, 23'h000000: byte address of buffer 0; word aligned.
- `BUF_STRIDE`, 23'h200000: byte distance between frame buffers.
- `fdma_clk` in 1: the single clock.
- `fdma_rstn` in 1: reset, asynchronous, active-low.
- `vid_de` in 1: `vid_data` valid this cycle.
- `vid_sof` in 1: first word of a frame; meaningful only with `vid_de`=1.
- `vid_data` in 32: pixel word.
- `fdma_waddr` out 23: byte address of the current transaction.
- `fdma_wareq` out 1: transaction request, held until acknowledged.
- `fdma_wsize` out 16: words in the current transaction.
- `fdma_wbusy` in 1: the engine is executing the transaction.
- `fdma_wvalid` in 1: FIFO pop strobe from the engine.
- `fdma_wdata` out 32: popped word, registered.
- `frame_done` out 1: one-cycle pulse when the last transaction of a frame completes.
- `frame_err` out 1: sticky; set on FIFO overflow or on a dropped or truncated frame; cleared by an accepted `vid_sof`.
- `wbuf_idx` out 2: index of the buffer being written.
- `last_buf_idx` out 2: index of the last completed buffer.

## Operation
**Frame arming**
- An accepted `vid_sof` arms the frame and performs these actions:
  - flush the FIFO;
  - set `remain` to `FRAME_WORDS`;
  - set the write address to `BASE_ADDR + wbuf_idx*BUF_STRIDE`;
  - clear `frame_err`.
- The sof word itself is stored.
- While unarmed, `vid_de` words are discarded.

**FIFO**
- Push on `vid_de` while armed.
- Push while full: the word is dropped and `frame_err` is set.
- Pop on `fdma_wvalid`. Pop while empty is illegal: the FIFO is not changed and `frame_err` is set.
- Simultaneous push and pop leave `level` unchanged.

**FSM**
- `S_IDLE`:
  - Let `sz = min(BURST_WORDS, remain)`.
  - If armed, `remain`>0 and `level`>=`sz`: latch `fdma_wsize`=`sz` and `fdma_waddr`, set `fdma_wareq`=1, go to `S_REQ`.
- `S_REQ`:
  - When `fdma_wbusy`=1 is sampled, clear `fdma_wareq` on that edge and go to `S_BUSY`.
  - `fdma_wareq` stays high however long the engine is occupied with reads.
- `S_BUSY`, on `fdma_wbusy`=0:
  - `addr += sz*4` (mod 2^23);
  - `remain -= sz`;
  - if the new `remain`=0: pulse `frame_done`, set `last_buf_idx`=`wbuf_idx`, advance the buffer, disarm;
  - go to `S_IDLE`.

**Boundary cases**
- `vid_sof` in `S_IDLE` while a frame is armed and `remain`>0: the old frame is truncated, `frame_err` is set, and the new frame is re-armed (flush plus reload).
- `vid_sof` in `S_REQ` or `S_BUSY`: the new frame is dropped. Every word is discarded until the next `vid_sof` seen in `S_IDLE`, and `frame_err` is set.
- Words arriving after `remain` reaches 0 and before the next sof: discarded.
- Reset mid-transaction: all state cleared immediately. The engine must be reset together with this block.

## Timing
- Reset values of all outputs: 0. Address register = `BASE_ADDR`.
- Pop latency: `fdma_wdata` is valid the cycle after `fdma_wvalid`, which matches the engine's one-cycle-early `fdma_wvalid`.
- Request latency: `level` reaching `sz` at cycle t gives `fdma_wareq`=1 at t+1.
- `fdma_waddr` and `fdma_wsize` are stable from `fdma_wareq` rising until `fdma_wbusy` falls.
- `level` width is log2(`FIFO_DEPTH`)+1. `remain` is 21 bits.

## Configuration
- `FDMA_WBUF_ROTATE_EN` defined:
  - buffer index advances 0→1→2→0 after each completed frame;
  - frame base = `BASE_ADDR + wbuf_idx*BUF_STRIDE`.
- `FDMA_WBUF_ROTATE_EN` undefined:
  - `wbuf_idx` and `last_buf_idx` are tied to 0;
  - every frame starts at `BASE_ADDR`.

## Test plan
- Reset, then sof plus 1024 words with `FRAME_WORDS`=1024 and an engine model that acks `fdma_wbusy` 2 cycles after request → 4 requests:
  - addresses 0x000, 0x400, 0x800, 0xC00, each size 256;
  - one `frame_done`;
  - SDRAM contents match the input.
- `FRAME_WORDS`=600 → sizes 256, 256, 88; last address 0x800.
- Engine holds off `fdma_wbusy` for 50 cycles → `fdma_wareq` stays high for 50 cycles, `fdma_waddr` stable, no data lost.
- Engine stalls and 600 words are pushed into the 512-word FIFO → 88 words dropped, `frame_err`=1, cleared by the next sof.
- sof during `S_BUSY` → that frame is discarded and `frame_err`=1; the following sof in `S_IDLE` writes correctly.
- `FDMA_WBUF_ROTATE_EN` defined, 4 frames → base addresses 0x000000, 0x200000, 0x400000, 0x000000; `last_buf_idx` sequence 0, 1, 2, 0.

Source files
------------

// File: rtl/fdma_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : fdma_frame_writer
// Purpose  : Write-side feeder for the app_fdma SDRAM burst engine. Buffers a
//            32-bit video word stream in a single-clock FIFO and slices each
//            frame into fdma_wareq transactions of at most BURST_WORDS words,
//            generating frame-buffer byte addresses and popped write data.
// Ports    : fdma_clk, fdma_rstn        - clock, async active-low reset
//            vid_de, vid_sof, vid_data  - incoming video word stream
//            fdma_waddr/wareq/wsize     - transaction request to the engine
//            fdma_wbusy, fdma_wvalid    - engine busy flag and pop strobe
//            fdma_wdata                 - popped word, one cycle after pop
//            frame_done, frame_err      - completion pulse, sticky error
//            wbuf_idx, last_buf_idx     - active / last completed buffer
// Config   : FDMA_WBUF_ROTATE_EN - when defined, frames rotate over three
//            buffers spaced BUF_STRIDE apart; otherwise every frame starts
//            at BASE_ADDR and both buffer indices read 0.
// Revision : 1.0 - initial release
// ============================================================================
module fdma_frame_writer #(
   parameter int unsigned BURST_WORDS = 256,
   parameter int unsigned FIFO_DEPTH  = 512,
   parameter int unsigned FRAME_WORDS = 307200,
   parameter logic [22:0] BASE_ADDR   = 23'h000000,
   parameter logic [22:0] BUF_STRIDE  = 23'h200000
) (
   input  logic        fdma_clk,
   input  logic        fdma_rstn,
   input  logic        vid_de,
   input  logic        vid_sof,
   input  logic [31:0] vid_data,
   output logic [22:0] fdma_waddr,
   output logic        fdma_wareq,
   output logic [15:0] fdma_wsize,
   input  logic        fdma_wbusy,
   input  logic        fdma_wvalid,
   output logic [31:0] fdma_wdata,
   output logic        frame_done,
   output logic        frame_err,
   output logic [1:0]  wbuf_idx,
   output logic [1:0]  last_buf_idx
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [20:0]   C_BURST = 21'(BURST_WORDS);
   localparam logic [20:0]   C_FRAME = 21'(FRAME_WORDS);
   localparam logic [LW-1:0] C_FULL  = LW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_BUSY = 2'd2
   } state_t;

   state_t        state_q;
   logic          armed_q;
   logic          drop_q;       // frame rejected mid-transaction: discard words
   logic [20:0]   remain_q;
   logic [22:0]   addr_q;
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [LW-1:0] level_q;
   logic [31:0]   mem_q [FIFO_DEPTH];
   logic          wareq_q;
   logic [22:0]   waddr_q;
   logic [15:0]   wsize_q;
   logic [31:0]   wdata_q;
   logic          done_q;
   logic          err_q;

   logic          w_sof_acc;
   logic          w_sof_rej;
   logic          w_word_ok;
   logic          w_full;
   logic          w_empty;
   logic          w_push_ok;
   logic          w_overflow;
   logic          w_pop_ok;
   logic          w_underflow;
   logic          w_wr_en;
   logic [AW-1:0] w_wr_idx;
   logic [20:0]   w_sz;
   logic          w_level_ok;
   logic [20:0]   w_remain_nx;
   logic [1:0]    w_buf;
   logic [22:0]   w_base;

`ifdef FDMA_WBUF_ROTATE_EN
   logic [1:0]    buf_q;
   logic [1:0]    last_buf_q;
   assign w_buf        = buf_q;
   assign last_buf_idx = last_buf_q;
`else
   assign w_buf        = 2'd0;
   assign last_buf_idx = 2'd0;
`endif

   // A sof is only honoured in S_IDLE; elsewhere it poisons the new frame.
   assign w_sof_acc   = vid_de & vid_sof & (state_q == S_IDLE);
   assign w_sof_rej   = vid_de & vid_sof & (state_q != S_IDLE);
   assign w_word_ok   = vid_de & ~vid_sof & armed_q & ~drop_q;
   assign w_full      = (level_q == C_FULL);
   assign w_empty     = (level_q == '0);
   assign w_push_ok   = w_word_ok & ~w_full;
   assign w_overflow  = w_word_ok & w_full;
   // The flush on an accepted sof takes precedence over any pop.
   assign w_pop_ok    = fdma_wvalid & ~w_empty & ~w_sof_acc;
   assign w_underflow = fdma_wvalid & w_empty;
   // The sof word lands in slot 0 of the freshly flushed FIFO.
   assign w_wr_en     = w_sof_acc | w_push_ok;
   assign w_wr_idx    = w_sof_acc ? '0 : wr_ptr_q;

   assign w_sz        = (remain_q < C_BURST) ? remain_q : C_BURST;
   assign w_level_ok  = (21'(level_q) >= w_sz);
   assign w_remain_nx = remain_q - 21'(wsize_q);
   assign w_base      = BASE_ADDR + ((w_buf == 2'd2) ? (BUF_STRIDE << 1) :
                                     (w_buf == 2'd1) ? BUF_STRIDE : 23'd0);

   always_ff @(posedge fdma_clk) begin
      if (w_wr_en) begin
         mem_q[w_wr_idx] <= vid_data;
      end
   end

   always_ff @(posedge fdma_clk or negedge fdma_rstn) begin
      if (!fdma_rstn) begin
         state_q  <= S_IDLE;
         armed_q  <= 1'b0;
         drop_q   <= 1'b0;
         remain_q <= '0;
         addr_q   <= BASE_ADDR;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         wareq_q  <= 1'b0;
         waddr_q  <= '0;
         wsize_q  <= '0;
         wdata_q  <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
`ifdef FDMA_WBUF_ROTATE_EN
         buf_q      <= 2'd0;
         last_buf_q <= 2'd0;
`endif
      end else begin
         done_q <= 1'b0;

         // FIFO pointers and occupancy
         if (w_sof_acc) begin
            wr_ptr_q <= AW'(1);
            rd_ptr_q <= '0;
            level_q  <= LW'(1);
         end else begin
            if (w_push_ok) begin
               wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_pop_ok) begin
               rd_ptr_q <= rd_ptr_q + AW'(1);
               wdata_q  <= mem_q[rd_ptr_q];
            end
            if (w_push_ok && !w_pop_ok) begin
               level_q <= level_q + LW'(1);
            end else if (!w_push_ok && w_pop_ok) begin
               level_q <= level_q - LW'(1);
            end
         end

         // Sticky error: a sof clears it unless it truncates a live frame.
         if (w_sof_acc) begin
            err_q <= armed_q && (remain_q != '0);
         end
         if (w_sof_rej || w_overflow || w_underflow) begin
            err_q <= 1'b1;
         end

         if (w_sof_acc) begin
            drop_q <= 1'b0;
         end else if (w_sof_rej) begin
            drop_q <= 1'b1;
         end

         case (state_q)
            S_IDLE: begin
               if (w_sof_acc) begin
                  armed_q  <= 1'b1;
                  remain_q <= C_FRAME;
                  addr_q   <= w_base;
               end else if (armed_q && (remain_q != '0) && w_level_ok) begin
                  wareq_q <= 1'b1;
                  waddr_q <= addr_q;
                  wsize_q <= 16'(w_sz);
                  state_q <= S_REQ;
               end
            end
            S_REQ: begin
               if (fdma_wbusy) begin
                  wareq_q <= 1'b0;
                  state_q <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (!fdma_wbusy) begin
                  addr_q   <= addr_q + 23'({wsize_q, 2'b00});
                  remain_q <= w_remain_nx;
                  if (w_remain_nx == '0) begin
                     done_q  <= 1'b1;
                     armed_q <= 1'b0;
`ifdef FDMA_WBUF_ROTATE_EN
                     last_buf_q <= buf_q;
                     buf_q      <= (buf_q == 2'd2) ? 2'd0 : buf_q + 2'd1;
`endif
                  end
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign fdma_wareq = wareq_q;
   assign fdma_waddr = waddr_q;
   assign fdma_wsize = wsize_q;
   assign fdma_wdata = wdata_q;
   assign frame_done = done_q;
   assign frame_err  = err_q;
   assign wbuf_idx   = w_buf;

endmodule
`default_nettype wire

// File: tb/tb_fdma_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fdma_frame_writer
// Purpose  : Directed bench for fdma_frame_writer (BURST 256, FIFO 512,
//            FRAME 600 words) with a behavioural burst-engine model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fdma_frame_writer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        vid_de;
   logic        vid_sof;
   logic [31:0] vid_data;
   logic [22:0] fdma_waddr;
   logic        fdma_wareq;
   logic [15:0] fdma_wsize;
   logic        fdma_wbusy;
   logic        fdma_wvalid;
   logic [31:0] fdma_wdata;
   logic        frame_done;
   logic        frame_err;
   logic [1:0]  wbuf_idx;
   logic [1:0]  last_buf_idx;

   int checks   = 0;
   int failures = 0;

   // engine model state
   int          eng_en    = 1;
   int          eng_hold  = 2;
   int          hold_bad  = 0;
   int          hold_max  = 0;
   logic [22:0] req_addr [$];
   int          req_size [$];
   logic [31:0] cap      [$];

   int          done_cnt = 0;
   logic [1:0]  done_last [$];
   int          exp_buf  = 0;
   int          c_sz [3] = '{256, 256, 88};

   fdma_frame_writer #(
      .BURST_WORDS (256),
      .FIFO_DEPTH  (512),
      .FRAME_WORDS (600),
      .BASE_ADDR   (23'h000000),
      .BUF_STRIDE  (23'h200000)
   ) dut (
      .fdma_clk     (clk),
      .fdma_rstn    (rst_n),
      .vid_de       (vid_de),
      .vid_sof      (vid_sof),
      .vid_data     (vid_data),
      .fdma_waddr   (fdma_waddr),
      .fdma_wareq   (fdma_wareq),
      .fdma_wsize   (fdma_wsize),
      .fdma_wbusy   (fdma_wbusy),
      .fdma_wvalid  (fdma_wvalid),
      .fdma_wdata   (fdma_wdata),
      .frame_done   (frame_done),
      .frame_err    (frame_err),
      .wbuf_idx     (wbuf_idx),
      .last_buf_idx (last_buf_idx)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_done === 1'b1) begin
         done_cnt = done_cnt + 1;
         done_last.push_back(last_buf_idx);
      end
   end

   // Burst-engine model: acks after eng_hold cycles, pops wsize words with a
   // continuous wvalid and captures fdma_wdata one cycle after each strobe.
   initial begin : engine
      logic [22:0] a;
      logic [15:0] n;
      int          hi;
      fdma_wbusy  = 1'b0;
      fdma_wvalid = 1'b0;
      forever begin
         @(negedge clk);
         if (eng_en != 0 && fdma_wareq === 1'b1) begin
            a = fdma_waddr;
            n = fdma_wsize;
            req_addr.push_back(a);
            req_size.push_back(int'(n));
            hi = 1;
            for (int k = 0; k < eng_hold; k++) begin
               @(negedge clk);
               if (fdma_wareq !== 1'b1 || fdma_waddr !== a || fdma_wsize !== n) hold_bad++;
               else hi++;
            end
            if (hi > hold_max) hold_max = hi;
            fdma_wbusy = 1'b1;
            @(negedge clk);
            if (fdma_wareq !== 1'b0) hold_bad++;
            for (int k = 0; k < int'(n); k++) begin
               fdma_wvalid = 1'b1;
               @(negedge clk);
               cap.push_back(fdma_wdata);
               if (fdma_waddr !== a || fdma_wsize !== n) hold_bad++;
            end
            fdma_wvalid = 1'b0;
            fdma_wbusy  = 1'b0;
         end
      end
   end

   function automatic logic [22:0] exp_base();
      return 23'h200000 * 23'(exp_buf);
   endfunction

   function automatic int addr_errs(input logic [22:0] base);
      int e = 0;
      if (req_addr.size() != 3) return 99;
      for (int j = 0; j < 3; j++) begin
         if (req_addr[j] !== base + 23'(j * 1024)) e++;
         if (req_size[j] != c_sz[j]) e++;
      end
      return e;
   endfunction

   function automatic int data_errs(input logic [15:0] seed, input int off,
                                    input int first, input int n);
      int e = 0;
      if (cap.size() < off + n) return n;
      for (int i = 0; i < n; i++) begin
         if (cap[off + i] !== {seed, 16'(first + i)}) e++;
      end
      return e;
   endfunction

   task automatic next_buf();
`ifdef FDMA_WBUF_ROTATE_EN
      exp_buf = (exp_buf == 2) ? 0 : exp_buf + 1;
`endif
   endtask

   task automatic clear_logs();
      req_addr.delete();
      req_size.delete();
      cap.delete();
      hold_bad = 0;
      hold_max = 0;
   endtask

   task automatic push_words(input logic [15:0] seed, input int first,
                             input int n, input bit sof);
      for (int i = 0; i < n; i++) begin
         vid_de   = 1'b1;
         vid_sof  = sof && (i == 0);
         vid_data = {seed, 16'(first + i)};
         @(negedge clk);
      end
      vid_de  = 1'b0;
      vid_sof = 1'b0;
   endtask

   task automatic wait_done(input int prev, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 4000; k++) begin
         if (done_cnt > prev) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      repeat (10) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      vid_de   = 1'b0;
      vid_sof  = 1'b0;
      vid_data = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({fdma_wareq, fdma_waddr, fdma_wsize, fdma_wdata, frame_done, frame_err} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: wareq=%0b waddr=%h wsize=%0d wdata=%h done=%0b err=%0b, required all 0",
                  fdma_wareq, fdma_waddr, fdma_wsize, fdma_wdata, frame_done, frame_err);
      end
      checks++;
      if ({wbuf_idx, last_buf_idx} !== 4'b0) begin
         failures++;
         $display("FAIL reset_buf_idx: wbuf=%0d last=%0d, required 0 0", wbuf_idx, last_buf_idx);
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (fdma_wareq !== 1'b0 || frame_err !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle: wareq=%0b err=%0b, required 0 0", fdma_wareq, frame_err);
      end
   endtask

   task automatic test_frame();
      int prev, e;
      bit ok;
      logic [22:0] base;
      clear_logs();
      base = exp_base();
      prev = done_cnt;
      checks++;
      if (wbuf_idx !== 2'(exp_buf)) begin
         failures++;
         $display("FAIL frame_wbuf_idx: got %0d required %0d", wbuf_idx, exp_buf);
      end
      push_words(16'hA001, 0, 600, 1'b1);
      wait_done(prev, ok);
      checks++;
      if (!ok || done_cnt != prev + 1) begin
         failures++;
         $display("FAIL frame_done_count: got %0d required 1", done_cnt - prev);
      end
      e = addr_errs(base);
      checks++;
      if (e != 0) begin
         failures++;
         $display("FAIL frame_addr_size: %0d errors over %0d requests, required 0 errors, base %h",
                  e, req_addr.size(), base);
      end
      e = data_errs(16'hA001, 0, 0, 600);
      checks++;
      if (e != 0 || cap.size() != 600) begin
         failures++;
         $display("FAIL frame_data: %0d bad of %0d captured, required 0 bad of 600", e, cap.size());
      end
      checks++;
      if (frame_err !== 1'b0) begin
         failures++;
         $display("FAIL frame_err_clean: got %0b required 0", frame_err);
      end
      checks++;
      if (done_last.size() == 0 || done_last[$] !== 2'(exp_buf)) begin
         failures++;
         $display("FAIL frame_last_buf: got %0d required %0d", last_buf_idx, exp_buf);
      end
      checks++;
      if (hold_bad != 0) begin
         failures++;
         $display("FAIL frame_protocol: %0d request/ack violations, required 0", hold_bad);
      end
      next_buf();
   endtask

   task automatic test_req_hold();
      int prev, e;
      bit ok;
      logic [22:0] base;
      clear_logs();
      base   = exp_base();
      prev   = done_cnt;
      eng_en = 0;
      push_words(16'hB002, 0, 256, 1'b1);
      checks++;
      if (fdma_wareq !== 1'b0) begin
         failures++;
         $display("FAIL req_latency_early: wareq=%0b in cycle level reaches 256, required 0", fdma_wareq);
      end
      @(negedge clk);
      checks++;
      if (fdma_wareq !== 1'b1 || fdma_waddr !== base || fdma_wsize !== 16'd256) begin
         failures++;
         $display("FAIL req_latency: wareq=%0b waddr=%h wsize=%0d, required 1 %h 256",
                  fdma_wareq, fdma_waddr, fdma_wsize, base);
      end
      eng_hold = 50;
      eng_en   = 1;
      push_words(16'hB002, 256, 344, 1'b0);
      wait_done(prev, ok);
      checks++;
      if (!ok || hold_max < 50 || hold_bad != 0) begin
         failures++;
         $display("FAIL req_hold: done=%0b wareq high %0d cycles with %0d violations, required >=50 and 0",
                  ok, hold_max, hold_bad);
      end
      e = addr_errs(base) + data_errs(16'hB002, 0, 0, 600);
      checks++;
      if (e != 0 || cap.size() != 600) begin
         failures++;
         $display("FAIL req_hold_data: %0d errors, %0d words captured, required 0 and 600", e, cap.size());
      end
      eng_hold = 2;
      next_buf();
   endtask

   task automatic test_truncate();
      int prev, e;
      bit ok;
      logic [22:0] base;
      clear_logs();
      base = exp_base();
      prev = done_cnt;
      push_words(16'hD004, 0, 100, 1'b1);
      push_words(16'hE005, 0, 600, 1'b1);
      checks++;
      if (frame_err !== 1'b1) begin
         failures++;
         $display("FAIL truncate_err: got %0b required 1", frame_err);
      end
      wait_done(prev, ok);
      e = addr_errs(base) + data_errs(16'hE005, 0, 0, 600);
      checks++;
      if (!ok || e != 0 || cap.size() != 600) begin
         failures++;
         $display("FAIL truncate_data: done=%0b %0d errors, %0d words, required 1 0 600", ok, e, cap.size());
      end
      next_buf();
   endtask

   task automatic test_overflow();
      int prev, e;
      bit ok;
      logic [22:0] base;
      clear_logs();
      base   = exp_base();
      prev   = done_cnt;
      eng_en = 0;
      push_words(16'hF006, 0, 300, 1'b1);
      checks++;
      if (frame_err !== 1'b0) begin
         failures++;
         $display("FAIL overflow_sof_clears: got %0b required 0", frame_err);
      end
      push_words(16'hF006, 300, 300, 1'b0);
      checks++;
      if (frame_err !== 1'b1 || fdma_wareq !== 1'b1) begin
         failures++;
         $display("FAIL overflow_err: err=%0b wareq=%0b, required 1 1", frame_err, fdma_wareq);
      end
      eng_en = 1;
      repeat (700) @(negedge clk);
      push_words(16'hF006, 600, 88, 1'b0);
      wait_done(prev, ok);
      e = addr_errs(base) + data_errs(16'hF006, 0, 0, 512) + data_errs(16'hF006, 512, 600, 88);
      checks++;
      if (!ok || e != 0 || cap.size() != 600) begin
         failures++;
         $display("FAIL overflow_data: done=%0b %0d errors, %0d words, required 1 0 600", ok, e, cap.size());
      end
      checks++;
      if (frame_err !== 1'b1) begin
         failures++;
         $display("FAIL overflow_sticky: got %0b required 1", frame_err);
      end
      next_buf();
      clear_logs();
      base = exp_base();
      prev = done_cnt;
      push_words(16'h1007, 0, 600, 1'b1);
      wait_done(prev, ok);
      e = addr_errs(base) + data_errs(16'h1007, 0, 0, 600);
      checks++;
      if (!ok || e != 0 || frame_err !== 1'b0) begin
         failures++;
         $display("FAIL overflow_recover: done=%0b %0d errors err=%0b, required 1 0 0", ok, e, frame_err);
      end
      next_buf();
   endtask

   task automatic test_sof_busy();
      int prev, e;
      bit ok, seen;
      logic [22:0] base;
      clear_logs();
      base = exp_base();
      prev = done_cnt;
      push_words(16'h2008, 0, 600, 1'b1);
      seen = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         if (fdma_wbusy === 1'b1) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL sof_busy_wait: wbusy=%0b never seen, required 1", fdma_wbusy);
      end
      push_words(16'h3009, 0, 20, 1'b1);
      checks++;
      if (frame_err !== 1'b1) begin
         failures++;
         $display("FAIL sof_busy_err: got %0b required 1", frame_err);
      end
      wait_done(prev, ok);
      e = addr_errs(base) + data_errs(16'h2008, 0, 0, 600);
      checks++;
      if (!ok || e != 0 || cap.size() != 600 || done_cnt != prev + 1) begin
         failures++;
         $display("FAIL sof_busy_old_frame: done=%0b %0d errors %0d words %0d dones, required 1 0 600 1",
                  ok, e, cap.size(), done_cnt - prev);
      end
      next_buf();
      clear_logs();
      base = exp_base();
      prev = done_cnt;
      push_words(16'h400A, 0, 600, 1'b1);
      wait_done(prev, ok);
      e = addr_errs(base) + data_errs(16'h400A, 0, 0, 600);
      checks++;
      if (!ok || e != 0 || frame_err !== 1'b0) begin
         failures++;
         $display("FAIL sof_busy_next_frame: done=%0b %0d errors err=%0b, required 1 0 0", ok, e, frame_err);
      end
      checks++;
      if (done_last.size() == 0 || done_last[$] !== 2'(exp_buf)) begin
         failures++;
         $display("FAIL sof_busy_last_buf: got %0d required %0d", last_buf_idx, exp_buf);
      end
      next_buf();
   endtask

   task automatic test_reset_mid();
      eng_en = 0;
      push_words(16'h500B, 0, 300, 1'b1);
      checks++;
      if (fdma_wareq !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_req: wareq=%0b required 1", fdma_wareq);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({fdma_wareq, fdma_waddr, fdma_wsize, fdma_wdata, frame_done, frame_err, wbuf_idx, last_buf_idx} !== '0) begin
         failures++;
         $display("FAIL reset_mid_async: wareq=%0b waddr=%h wsize=%0d err=%0b wbuf=%0d, required all 0",
                  fdma_wareq, fdma_waddr, fdma_wsize, frame_err, wbuf_idx);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (fdma_wareq !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_idle: wareq=%0b required 0", fdma_wareq);
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_req_hold();
      test_truncate();
      test_overflow();
      test_sof_busy();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
